gpu_fill_engine: RTL and testbench
==================================

# gpu_fill_engine

Rectangle-fill raster engine that turns queued drawing ops into framebuffer pixel writes, one pixel per enabled clock. It buffers ops in an internal FIFO, clips every op to the active area, and drives the framebuffer write port directly. It generalises the single-bit, externally-fed GPU path with parametrised colour depth, queue depth, hardware clipping, a whole-frame clear op, abort-on-flush, and completion/status outputs. It sits between the game-logic op producer and the framebuffer.

## Interface

Parameters:

- HOR_ACTIVE_PIXELS, 640, framebuffer width.
- VER_ACTIVE_PIXELS, 480, framebuffer height.
- COLOR_WIDTH, 1, bits per pixel.
- FIFO_DEPTH, 4, op queue depth; must be a power of two, ≥2.
- Derived widths:
  - X_W = $clog2(HOR_ACTIVE_PIXELS)
  - Y_W = $clog2(VER_ACTIVE_PIXELS)
  - ADDR_W = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)

Ports:

- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  engine clock enable; gates op pop and pixel emission only, never FIFO push.
- flush  in  1  synchronous abort; empties the FIFO and cancels the current op.
- op_valid  in  1  producer has an op.
- op_ready  out  1  combinational: !fifo_full & !flush.
- op_kind  in  1  0 = FILL rect, 1 = CLEAR whole frame. For CLEAR, x/y/w/h are ignored.
- op_x  in  X_W  left column.
- op_y  in  Y_W  top row.
- op_w  in  X_W+1  width in pixels.
- op_h  in  Y_W+1  height in pixels.
- op_color  in  COLOR_WIDTH  fill value.
- wr_en  out  1  registered pixel write strobe.
- wr_addr  out  ADDR_W  registered linear address, y*HOR_ACTIVE_PIXELS+x.
- wr_data  out  COLOR_WIDTH  registered pixel value.
- op_done  out  1  one-cycle pulse when an op finishes, including ops clipped to empty.
- busy  out  1  state≠IDLE or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  ops currently queued.

## Operation

- **Push.** An op is accepted on a clock edge with op_valid & op_ready. Push is independent of ce. A pop in the same cycle never makes room for a push while the FIFO is full.
- **IDLE.** If ce and the FIFO is non-empty: pop the head op, go to LOAD.
- **LOAD** (one cycle, ce-gated): compute clipped bounds.
  - FILL: x0=op_x, y0=op_y, x_end=min(op_x+op_w, HOR), y_end=min(op_y+op_h, VER). Intermediate sums use X_W+2 / Y_W+2 bits.
  - CLEAR: x0=0, y0=0, x_end=HOR, y_end=VER.
  - Empty if x0≥HOR, y0≥VER, x_end≤x0 or y_end≤y0. An empty op pulses op_done and returns to IDLE.
  - Otherwise set cx=x0, cy=y0, addr=y0*HOR+x0, go to DRAW.
- **DRAW.** On each ce cycle, register wr_en=1, wr_addr=addr, wr_data=color. Then advance:
  - Within a row: cx+1, addr+1.
  - At row end (cx=x_end-1): cx=x0, cy+1, addr += HOR-(x_end-x0-1).
  - On the last pixel (cx=x_end-1 & cy=y_end-1): pulse op_done and go to IDLE.
- **Write order.** Pixels are emitted in raster order, row-major. No multiplier is used in DRAW; the single y0*HOR product is computed in LOAD only.
- **ce low.** wr_en is registered 0; wr_addr, wr_data and all state are held.
- **flush.** The FIFO is cleared, state goes to IDLE, and wr_en is registered 0. The aborted op gets no op_done.
- **Reset.** The FIFO is emptied and state goes to IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, op_done=0.
  - Result: busy=0, fifo_level=0, op_ready=1 (with flush low).

## Timing

- **Latency.** Op accepted at edge E into an empty, idle engine with ce held high:
  - IDLE sees it at E+1.
  - LOAD runs in the cycle after E+1.
  - The first wr_en is high in the cycle after edge E+3.
- **Throughput.** One pixel per ce cycle. There are exactly 2 ce cycles of overhead between consecutive ops (IDLE, LOAD), with no write bubble inside an op.
- **op_done timing.** op_done is registered in the same cycle as the last wr_en. For an empty op it is registered in the cycle after LOAD.
- **fifo_level timing.** fifo_level updates on the edge after a push or pop; a simultaneous push and pop leaves it unchanged.
- **flush timing.** flush takes effect on the edge it is sampled high. op_ready is 0 while flush is high.
- **Reset timing.** Reset assertion clears outputs immediately (asynchronously). Deassertion is synchronised externally.

## Test plan

- **Single rect.** HOR=640, FILL x=10 y=5 w=3 h=2 color=1.
  - Exactly six writes: 3210, 3211, 3212, 3850, 3851, 3852, all data 1.
  - op_done coincides with the 3852 write; busy drops the next cycle.
- **Clipping.** FILL x=638 y=479 w=5 h=5: only two writes, 307198 and 307199, then op_done.
- **Empty ops.** FILL w=0; FILL x=700; FILL y=480: no wr_en, one op_done pulse per op, 3 pulses total.
- **FIFO full.** FIFO_DEPTH=4, ce=0, push 5 ops back-to-back.
  - op_ready goes low after the 4th push; fifo_level=4.
  - The 5th op is held by the producer; after ce=1 it drains in order.
- **Flush mid-op.** CLEAR with color=1, plus 2 queued ops; assert flush after 100 writes.
  - wr_en is 0 the next cycle; fifo_level=0, busy=0.
  - No op_done for any of the three ops.
  - A following CLEAR produces exactly 307200 writes.
- **ce gating and reset.**
  - ce toggling 1/0 during a 2x2 FILL: writes occur only in cycles following ce=1 edges, with unchanged addresses and order.
  - rst low mid-DRAW: wr_en, op_done and busy are 0 immediately.

Source files
------------

// File: rtl/gpu_fill_engine.sv
// Small first-word-fall-through queue holding pending drawing ops.
// Latency: a pushed entry is visible at head_dat one edge after the push.
// Backpressure: push is ignored while full; pop in the same cycle does not free a slot.
module gpu_fill_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push_vld & ~full & ~clr;
    assign do_pop   = pop_vld & ~empty & ~clr;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Rectangle-fill / frame-clear raster engine writing one clipped pixel per enabled clock.
// Latency: first wr_en registered 3 edges after an op is accepted into an idle engine.
// Backpressure: op_ready = !fifo_full & !flush; ce low stalls popping and drawing only.
module gpu_fill_engine #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int COLOR_WIDTH       = 1,
    parameter int FIFO_DEPTH        = 4,
    localparam int X_W    = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_W    = $clog2(VER_ACTIVE_PIXELS),
    localparam int ADDR_W = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS),
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   flush,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic                   op_kind,
    input  logic [X_W-1:0]         op_x,
    input  logic [Y_W-1:0]         op_y,
    input  logic [X_W:0]           op_w,
    input  logic [Y_W:0]           op_h,
    input  logic [COLOR_WIDTH-1:0] op_color,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [COLOR_WIDTH-1:0] wr_data,
    output logic                   op_done,
    output logic                   busy,
    output logic [LVL_W-1:0]       fifo_level
);
    typedef struct packed {
        logic                   kind;
        logic [X_W-1:0]         x;
        logic [Y_W-1:0]         y;
        logic [X_W:0]           w;
        logic [Y_W:0]           h;
        logic [COLOR_WIDTH-1:0] color;
    } op_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW} state_t;

    localparam logic [X_W:0]   HOR_X = (X_W + 1)'(HOR_ACTIVE_PIXELS);
    localparam logic [X_W+1:0] HOR_S = (X_W + 2)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_W:0]   VER_Y = (Y_W + 1)'(VER_ACTIVE_PIXELS);
    localparam logic [Y_W+1:0] VER_S = (Y_W + 2)'(VER_ACTIVE_PIXELS);

    state_t state, state_nxt;
    op_t    in_op, head_op, cur_op;
    logic   fifo_full, fifo_empty;
    logic   push_vld, pop_vld;

    logic [X_W-1:0]    x0, cx;
    logic [X_W:0]      x_end;
    logic [Y_W-1:0]    cy;
    logic [Y_W:0]      y_end;
    logic [ADDR_W-1:0] addr, row_step;

    logic [X_W+1:0]    x_sum;
    logic [Y_W+1:0]    y_sum;
    logic [X_W-1:0]    ld_x0;
    logic [Y_W-1:0]    ld_y0;
    logic [X_W:0]      ld_x_end;
    logic [Y_W:0]      ld_y_end;
    logic              ld_empty;
    logic [ADDR_W-1:0] ld_base, ld_step;
    logic              row_end, last_px;

    always_comb begin
        in_op       = '0;
        in_op.kind  = op_kind;
        in_op.x     = op_x;
        in_op.y     = op_y;
        in_op.w     = op_w;
        in_op.h     = op_h;
        in_op.color = op_color;
    end

    assign op_ready = ~fifo_full & ~flush;
    assign push_vld = op_valid & op_ready;
    assign busy     = (state != S_IDLE) | ~fifo_empty;

    gpu_fill_fifo #(
        .WIDTH ($bits(op_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_op_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push_vld (push_vld),
        .push_dat (in_op),
        .pop_vld  (pop_vld),
        .head_dat (head_op),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Clip against the active area; the only multiply lives here, off the per-pixel path.
    always_comb begin
        x_sum    = {2'b00, cur_op.x} + {1'b0, cur_op.w};
        y_sum    = {2'b00, cur_op.y} + {1'b0, cur_op.h};
        ld_x0    = cur_op.kind ? '0 : cur_op.x;
        ld_y0    = cur_op.kind ? '0 : cur_op.y;
        ld_x_end = (cur_op.kind || x_sum > HOR_S) ? HOR_X : x_sum[X_W:0];
        ld_y_end = (cur_op.kind || y_sum > VER_S) ? VER_Y : y_sum[Y_W:0];
        ld_empty = ({1'b0, ld_x0} >= HOR_X) | ({1'b0, ld_y0} >= VER_Y) |
                   (ld_x_end <= {1'b0, ld_x0}) | (ld_y_end <= {1'b0, ld_y0});
        ld_base  = ADDR_W'(ld_y0 * HOR_ACTIVE_PIXELS) + ADDR_W'(ld_x0);
        ld_step  = ADDR_W'(HOR_ACTIVE_PIXELS) - ADDR_W'(ld_x_end - {1'b0, ld_x0}) + ADDR_W'(1);
    end

    assign row_end = ({1'b0, cx} == x_end - (X_W + 1)'(1));
    assign last_px = row_end & ({1'b0, cy} == y_end - (Y_W + 1)'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop_vld   = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
        end else if (ce) begin
            case (state)
                S_IDLE: if (!fifo_empty) begin
                    pop_vld   = 1'b1;
                    state_nxt = S_LOAD;
                end
                S_LOAD:  state_nxt = ld_empty ? S_IDLE : S_DRAW;
                S_DRAW:  if (last_px) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_op   <= '0;
            x0       <= '0;
            x_end    <= '0;
            y_end    <= '0;
            cx       <= '0;
            cy       <= '0;
            addr     <= '0;
            row_step <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            op_done  <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            op_done <= 1'b0;
            if (!flush && ce) begin
                case (state)
                    S_IDLE: if (pop_vld) cur_op <= head_op;
                    S_LOAD: begin
                        if (ld_empty) begin
                            op_done <= 1'b1;
                        end else begin
                            x0       <= ld_x0;
                            x_end    <= ld_x_end;
                            y_end    <= ld_y_end;
                            cx       <= ld_x0;
                            cy       <= ld_y0;
                            addr     <= ld_base;
                            row_step <= ld_step;
                        end
                    end
                    S_DRAW: begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= cur_op.color;
                        if (last_px) begin
                            op_done <= 1'b1;
                        end else if (row_end) begin
                            cx   <= x0;
                            cy   <= cy + 1'b1;
                            addr <= addr + row_step;
                        end else begin
                            cx   <= cx + 1'b1;
                            addr <= addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gpu_fill_engine.sv
// Bench for gpu_fill_engine: table vectors, hand-written timing sequences, random ops
// checked against a raster model computed directly from the clip rules.
module tb_gpu_fill_engine;
    localparam int HOR   = 640;
    localparam int VER   = 48;
    localparam int CW    = 2;
    localparam int DEPTH = 4;
    localparam int XW    = $clog2(HOR);
    localparam int YW    = $clog2(VER);
    localparam int AW    = $clog2(HOR * VER);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int NV    = 9;
    localparam int NR    = 40;

    typedef struct { int kind; int x; int y; int w; int h; int color; } op_rec_t;
    typedef struct { op_rec_t op; int n; int first; int last; } vec_t;

    logic          clk = 1'b0, rst = 1'b1, ce = 1'b0, flush = 1'b0, op_valid = 1'b0;
    logic          op_kind = 1'b0;
    logic [XW-1:0] op_x = '0;
    logic [YW-1:0] op_y = '0;
    logic [XW:0]   op_w = '0;
    logic [YW:0]   op_h = '0;
    logic [CW-1:0] op_color = '0;
    logic          op_ready, wr_en, op_done, busy;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic [LW-1:0] fifo_level;

    gpu_fill_engine #(
        .HOR_ACTIVE_PIXELS (HOR),
        .VER_ACTIVE_PIXELS (VER),
        .COLOR_WIDTH       (CW),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .ce (ce), .flush (flush),
        .op_valid (op_valid), .op_ready (op_ready), .op_kind (op_kind),
        .op_x (op_x), .op_y (op_y), .op_w (op_w), .op_h (op_h), .op_color (op_color),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .op_done (op_done), .busy (busy), .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Monitor: records every write and op_done, written only by these processes.
    int   got_addr[$], got_data[$], got_cyc[$], done_pos[$];
    int   cyc_cnt = 0, bad_ce = 0, busy_done_cnt = 0;
    logic ce_at_edge = 1'b0;

    always @(posedge clk) begin
        cyc_cnt    <= cyc_cnt + 1;
        ce_at_edge <= ce;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                got_addr.push_back(int'(wr_addr));
                got_data.push_back(int'(wr_data));
                got_cyc.push_back(cyc_cnt);
                if (!ce_at_edge) bad_ce++;
            end
            if (op_done) begin
                done_pos.push_back(got_addr.size());
                if (busy) busy_done_cnt++;
            end
        end
    end

    int   checks = 0, errors = 0;
    int   exp_addr[$], exp_data[$], exp_done[$];
    int   g0, d0, ce0, bd0;
    vec_t vt[NV];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic op_rec_t mk(input int k, input int x, input int y,
                                   input int w, input int h, input int c);
        op_rec_t o;
        o.kind = k; o.x = x; o.y = y; o.w = w; o.h = h; o.color = c;
        return o;
    endfunction

    task automatic set_vec(input int i, input op_rec_t o, input int n, input int f, input int l);
        vt[i].op = o; vt[i].n = n; vt[i].first = f; vt[i].last = l;
    endtask

    // Reference: the clipped rectangle enumerated row by row.
    task automatic model_op(input op_rec_t o);
        int xs, ys, xe, ye;
        xs = (o.kind != 0) ? 0 : o.x;
        ys = (o.kind != 0) ? 0 : o.y;
        xe = (o.kind != 0) ? HOR : ((o.x + o.w < HOR) ? o.x + o.w : HOR);
        ye = (o.kind != 0) ? VER : ((o.y + o.h < VER) ? o.y + o.h : VER);
        for (int r = ys; r < ye; r++)
            for (int c = xs; c < xe; c++) begin
                exp_addr.push_back(r * HOR + c);
                exp_data.push_back(o.color);
            end
        exp_done.push_back(exp_addr.size());
    endtask

    task automatic drive(input op_rec_t o);
        op_kind  = 1'(o.kind);
        op_x     = XW'(o.x);
        op_y     = YW'(o.y);
        op_w     = (XW + 1)'(o.w);
        op_h     = (YW + 1)'(o.h);
        op_color = CW'(o.color);
    endtask

    task automatic push_op(input op_rec_t o);
        int n = 0;
        drive(o);
        op_valid = 1'b1;
        while (!op_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("push ready", op_ready, 1);
        if (op_ready) begin
            @(posedge clk); #1;
            model_op(o);
        end
        op_valid = 1'b0;
    endtask

    task automatic start_seg();
        g0 = got_addr.size(); d0 = done_pos.size(); ce0 = bad_ce; bd0 = busy_done_cnt;
        exp_addr.delete(); exp_data.delete(); exp_done.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin @(posedge clk); #1; n++; end
        chk({name, " drained"}, busy, 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_stream(input string name);
        int ng, nd, bad;
        ng = got_addr.size() - g0;
        chk({name, " write count"}, ng, exp_addr.size());
        bad = 0;
        for (int i = 0; i < exp_addr.size(); i++)
            if (i >= ng || got_addr[g0+i] != exp_addr[i] || got_data[g0+i] != exp_data[i]) bad++;
        chk({name, " pixel mismatches"}, bad, 0);
        nd = done_pos.size() - d0;
        chk({name, " op_done count"}, nd, exp_done.size());
        bad = 0;
        for (int i = 0; i < exp_done.size(); i++)
            if (i >= nd || done_pos[d0+i] - g0 != exp_done[i]) bad++;
        chk({name, " op_done position"}, bad, 0);
    endtask

    function automatic op_rec_t rand_op();
        int x;
        x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 639));
        return mk(0, x, int'($urandom_range(0, 63)), int'($urandom_range(0, 12)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int      n, k, ng, e_cyc, sent, cyc;
        logic    acc;
        op_rec_t cur;
        op_rec_t fq[5];

        set_vec(0, mk(0, 10, 5, 3, 2, 1),     6,  3210,  3852);
        set_vec(1, mk(0, 638, 47, 5, 5, 1),   2,  30718, 30719);
        set_vec(2, mk(0, 10, 5, 0, 2, 1),     0,  0,     0);
        set_vec(3, mk(0, 700, 5, 3, 2, 1),    0,  0,     0);
        set_vec(4, mk(0, 10, 48, 3, 2, 1),    0,  0,     0);
        set_vec(5, mk(0, 630, 0, 10, 1, 3),   10, 630,   639);
        set_vec(6, mk(0, 5, 0, 2047, 1, 2),   635, 5,    639);
        set_vec(7, mk(0, 0, 40, 1, 127, 3),   8,  25600, 30080);
        set_vec(8, mk(0, 3, 2, 4, 0, 1),      0,  0,     0);

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("reset wr_en", wr_en, 0);
        chk("reset wr_addr", wr_addr, 0);
        chk("reset wr_data", wr_data, 0);
        chk("reset op_done", op_done, 0);
        chk("reset busy", busy, 0);
        chk("reset fifo_level", fifo_level, 0);
        chk("reset op_ready", op_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        ce = 1'b1;

        // Single-op vectors
        for (int i = 0; i < NV; i++) begin
            start_seg();
            push_op(vt[i].op);
            wait_idle($sformatf("vec%0d", i), 3000);
            ng = got_addr.size() - g0;
            chk($sformatf("vec%0d writes", i), ng, vt[i].n);
            if (vt[i].n > 0) begin
                chk($sformatf("vec%0d first addr", i), (ng > 0) ? got_addr[g0] : -1, vt[i].first);
                chk($sformatf("vec%0d last addr", i), (ng > 0) ? got_addr[got_addr.size()-1] : -1, vt[i].last);
            end
            chk($sformatf("vec%0d done pulses", i), done_pos.size() - d0, 1);
            chk($sformatf("vec%0d busy at done", i), busy_done_cnt - bd0, 0);
            check_stream($sformatf("vec%0d", i));
        end

        // Latency, in-op throughput, inter-op overhead
        start_seg();
        push_op(mk(0, 0, 0, 2, 1, 1));
        e_cyc = cyc_cnt;
        chk("latency level after push", fifo_level, 1);
        push_op(mk(0, 100, 1, 1, 1, 2));
        chk("level on push+pop", fifo_level, 1);
        wait_idle("latency", 50);
        check_stream("latency");
        if (got_addr.size() - g0 >= 3) begin
            chk("first write latency", got_cyc[g0] - e_cyc, 3);
            chk("in-op write spacing", got_cyc[g0+1] - got_cyc[g0], 1);
            chk("inter-op write spacing", got_cyc[g0+2] - got_cyc[g0+1], 3);
        end

        // FIFO full with ce low; 5th op held until a pop frees room
        start_seg();
        ce = 1'b0;
        fq[0] = mk(0, 0, 0, 1, 1, 1);
        fq[1] = mk(0, 10, 2, 2, 2, 2);
        fq[2] = mk(0, 0, 0, 0, 3, 3);
        fq[3] = mk(0, 639, 47, 4, 4, 1);
        fq[4] = mk(0, 20, 20, 3, 1, 3);
        for (int i = 0; i < 4; i++) begin
            push_op(fq[i]);
            chk($sformatf("fifo level after push %0d", i + 1), fifo_level, i + 1);
        end
        chk("op_ready when full", op_ready, 0);
        drive(fq[4]);
        op_valid = 1'b1;
        @(posedge clk); #1;
        chk("op_ready held full", op_ready, 0);
        chk("level held full", fifo_level, 4);
        ce = 1'b1;
        push_op(fq[4]);
        wait_idle("fifo full", 200);
        check_stream("fifo full");

        // ce toggling during a 2x2 fill
        start_seg();
        push_op(mk(0, 100, 10, 2, 2, 3));
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; ce = ~ce; n++; end
        chk("ce toggle drained", busy, 0);
        ce = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("writes after ce-low edges", bad_ce - ce0, 0);
        check_stream("ce toggle");

        // Random ops, random ce, random producer gaps
        start_seg();
        cur = rand_op();
        sent = 0;
        cyc = 0;
        while ((sent < NR || busy) && cyc < 20000) begin
            ce = ($urandom_range(0, 3) != 0);
            drive(cur);
            op_valid = (sent < NR) && ($urandom_range(0, 2) != 0);
            acc = op_valid && op_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                model_op(cur);
                sent++;
                cur = rand_op();
            end
        end
        op_valid = 1'b0;
        ce = 1'b1;
        chk("random ops sent", sent, NR);
        wait_idle("random", 2000);
        check_stream("random");

        // Flush mid-CLEAR with two queued ops
        start_seg();
        push_op(mk(1, 5, 5, 0, 0, 1));
        push_op(mk(0, 0, 0, 2, 2, 2));
        push_op(mk(0, 7, 7, 3, 3, 3));
        n = got_addr.size() - g0;
        k = 0;
        while (n < 100 && k < 300) begin
            @(posedge clk); #1;
            if (wr_en) n++;
            k++;
        end
        chk("writes before flush", n, 100);
        flush = 1'b1;
        #1;
        chk("op_ready during flush", op_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("wr_en after flush", wr_en, 0);
        chk("fifo_level after flush", fifo_level, 0);
        chk("busy after flush", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        exp_addr.delete(); exp_data.delete(); exp_done.delete();
        for (int i = 0; i < 100; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(1);
        end
        check_stream("flush");

        start_seg();
        push_op(mk(1, 0, 0, 0, 0, 2));
        wait_idle("clear", 40000);
        chk("clear write total", got_addr.size() - g0, HOR * VER);
        check_stream("clear");

        // Asynchronous reset mid-DRAW with an op still queued
        push_op(mk(0, 0, 0, 4, 4, 1));
        push_op(mk(0, 50, 3, 2, 2, 2));
        n = 0;
        while (!wr_en && n < 20) begin @(posedge clk); #1; n++; end
        chk("drawing before reset", wr_en, 1);
        #3 rst = 1'b0;
        #1;
        chk("async reset wr_en", wr_en, 0);
        chk("async reset op_done", op_done, 0);
        chk("async reset busy", busy, 0);
        chk("async reset fifo_level", fifo_level, 0);
        chk("async reset wr_addr", wr_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
